ifetch_ctrl: RTL and testbench

Instruction-fetch controller sitting directly downstream of the program-counter register. It reads the current PC, runs a request/acknowledge transaction to instruction memory, and holds the fetched word for decode until decode accepts it. On acceptance it pulses the PC register's load enable so the PC advances by +4 or by the branch offset.

---
 rtl/riscv_if_pkg.sv | 20 ++
 rtl/ifetch_timer.sv | 25 ++
 rtl/ifetch_ctrl.sv | 103 ++++++++++
 tb/tb_ifetch_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package riscv_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_FAULT
  } if_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_BUSERR   = 2'b10,
    FC_TIMEOUT  = 2'b11
  } fault_cause_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/ifetch_timer.sv
// Saturating wait counter for the REQ phase; expired marks the last allowed cycle.
module ifetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic asyncreset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge asyncreset) begin
    if (!asyncreset)              cnt <= '0;
    else if (clear)               cnt <= '0;
    else if (en && cnt != LAST)   cnt <= cnt + W'(1);
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: issues one imem request per PC, holds the word for decode,
// and pulses pc_load when decode accepts it.
module ifetch_ctrl
  import riscv_if_pkg::*;
#(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] NOP     = NOP_INSN
) (
  input  logic        clk,
  input  logic        asyncreset,
  input  logic [31:0] pc_in,
  output logic        pc_load,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_err,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  if_state_e    state_q, state_d;
  fault_cause_e cause_q, cause_d;
  logic         latch;
  logic         tmr_en;
  logic         expired;
  logic [31:0]  inst_q, ipc_q;

  ifetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk        (clk),
    .asyncreset (asyncreset),
    .clear      (state_q != ST_REQ),
    .en         (tmr_en),
    .expired    (expired)
  );

  always_ff @(posedge clk or negedge asyncreset) begin
    if (!asyncreset) begin
      state_q <= ST_IDLE;
      cause_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // REQ priority: misalignment, bus error, ack, timeout.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    latch   = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (pc_in[1:0] != 2'b00) begin
          state_d = ST_FAULT;
          cause_d = FC_MISALIGN;
        end else if (imem_err) begin
          state_d = ST_FAULT;
          cause_d = FC_BUSERR;
        end else if (imem_ack) begin
          state_d = ST_HOLD;
          latch   = 1'b1;
        end else if (expired) begin
          state_d = ST_FAULT;
          cause_d = FC_TIMEOUT;
        end else begin
          tmr_en  = 1'b1;
        end
      end
      ST_HOLD:  if (inst_ready) state_d = ST_REQ;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge asyncreset) begin
    if (!asyncreset) begin
      inst_q <= NOP;
      ipc_q  <= '0;
    end else if (latch) begin
      inst_q <= imem_rdata;
      ipc_q  <= pc_in;
    end else if (pc_load) begin
      inst_q <= NOP;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_in;
  assign inst_valid  = (state_q == ST_HOLD);
  assign pc_load     = (state_q == ST_HOLD) && inst_ready;
  assign inst_out    = inst_q;
  assign inst_pc     = ipc_q;
  assign fault       = (state_q == ST_FAULT);
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: per-cycle behavioural model plus directed literal checks.
module tb_ifetch_ctrl;

  localparam int          TO   = 16;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        asyncreset, pc_load, imem_req, imem_ack, imem_err, inst_valid, inst_ready, fault;
  logic [31:0] pc_in, imem_addr, imem_rdata, inst_out, inst_pc;
  logic [1:0]  fault_cause;

  logic        rst4, pcload4, req4, ack4, err4, valid4, ready4, fault4;
  logic [31:0] pc4, addr4, rdata4, out4, ipc4;
  logic [1:0]  cause4;

  int n_cmp = 0;
  int n_err = 0;

  ifetch_ctrl dut (
    .clk(clk), .asyncreset(asyncreset), .pc_in(pc_in), .pc_load(pc_load),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_err(imem_err),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc), .fault(fault), .fault_cause(fault_cause)
  );

  ifetch_ctrl #(.TIMEOUT(4)) dut4 (
    .clk(clk), .asyncreset(rst4), .pc_in(pc4), .pc_load(pcload4),
    .imem_req(req4), .imem_addr(addr4), .imem_ack(ack4), .imem_err(err4),
    .imem_rdata(rdata4), .inst_valid(valid4), .inst_ready(ready4),
    .inst_out(out4), .inst_pc(ipc4), .fault(fault4), .fault_cause(cause4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: phase 0 idle, 1 waiting on memory, 2 holding a word, 3 faulted.
  int          m_phase, m_n;
  logic [31:0] m_inst, m_pc;
  logic [1:0]  m_cause;

  always @(posedge clk or negedge asyncreset) begin
    if (!asyncreset) begin
      m_phase <= 0; m_n <= 0; m_inst <= NOPW; m_pc <= 0; m_cause <= 2'd0;
    end else begin
      case (m_phase)
        0: begin m_phase <= 1; m_n <= 0; end
        1: begin
          if (pc_in % 4 != 0)      begin m_phase <= 3; m_cause <= 2'd1; end
          else if (imem_err)       begin m_phase <= 3; m_cause <= 2'd2; end
          else if (imem_ack)       begin m_phase <= 2; m_inst <= imem_rdata; m_pc <= pc_in; end
          else if (m_n + 1 == TO)  begin m_phase <= 3; m_cause <= 2'd3; end
          else                     m_n <= m_n + 1;
        end
        2: if (inst_ready) begin m_phase <= 1; m_n <= 0; end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    check("req",      imem_req,    m_phase == 1);
    check("valid",    inst_valid,  m_phase == 2);
    check("pc_load",  pc_load,     (m_phase == 2) && inst_ready);
    check("inst_out", inst_out,    (m_phase == 2) ? m_inst : NOPW);
    check("inst_pc",  inst_pc,     m_pc);
    check("fault",    fault,       m_phase == 3);
    check("cause",    fault_cause, m_cause);
    if (m_phase == 1) check("addr", imem_addr, pc_in);
  end

  initial begin
    asyncreset = 0; pc_in = 0; imem_ack = 0; imem_err = 0; imem_rdata = 0; inst_ready = 0;
    rst4 = 0; pc4 = 32'h40; ack4 = 0; err4 = 0; rdata4 = 0; ready4 = 0;
    repeat (2) cyc();
    check("L_rst_out", inst_out, NOPW);
    check("L_rst_req", imem_req, 0);
    check("L_rst_cause", fault_cause, 0);

    // first fetch, ack in the first REQ cycle
    asyncreset = 1;
    imem_ack = 1; imem_rdata = 32'h0050_0093;
    check("L_idle_req", imem_req, 0);
    cyc();
    check("L_t1_req", imem_req, 1);
    check("L_t1_addr", imem_addr, 0);
    cyc();
    imem_ack = 0; inst_ready = 1; #1;
    check("L_t1_valid", inst_valid, 1);
    check("L_t1_out", inst_out, 32'h0050_0093);
    check("L_t1_pc", inst_pc, 0);
    check("L_t1_load", pc_load, 1);
    cyc();
    pc_in = 4; inst_ready = 0; #1;
    check("L_t1_load_off", pc_load, 0);
    check("L_t1_nop", inst_out, NOPW);

    // ack delayed 5 cycles, decode stalls 3 cycles
    for (int i = 0; i < 5; i++) begin
      check("L_t2_addr", imem_addr, 4);
      check("L_t2_req", imem_req, 1);
      cyc();
    end
    imem_ack = 1; imem_rdata = 32'h00a0_0113;
    check("L_t2_addr6", imem_addr, 4);
    cyc();
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      check("L_t2_stall_load", pc_load, 0);
      check("L_t2_stall_out", inst_out, 32'h00a0_0113);
      cyc();
    end
    inst_ready = 1; #1;
    check("L_t2_load", pc_load, 1);
    check("L_t2_pc", inst_pc, 4);
    cyc();
    pc_in = 8; inst_ready = 0;

    // back-to-back fetches
    for (int k = 0; k < 4; k++) begin
      imem_ack = 1; imem_rdata = 32'h0000_0100 + k;
      cyc();
      imem_ack = 0; inst_ready = 1; #1;
      check("L_tp_valid", inst_valid, 1);
      cyc();
      pc_in = pc_in + 4; inst_ready = 0;
    end

    // err and ack together
    imem_err = 1; imem_ack = 1;
    cyc();
    imem_err = 0; imem_ack = 0; #1;
    check("L_err_fault", fault, 1);
    check("L_err_cause", fault_cause, 2'd2);
    check("L_err_valid", inst_valid, 0);
    repeat (3) cyc();
    check("L_err_sticky", fault_cause, 2'd2);
    asyncreset = 0; #1;
    check("L_err_rst", fault, 0);
    cyc();

    // misaligned PC
    pc_in = 32'h0000_0006; asyncreset = 1;
    cyc();
    imem_ack = 1; imem_rdata = 32'h1111_1111;
    check("L_mis_req", imem_req, 1);
    cyc();
    imem_ack = 0;
    check("L_mis_cause", fault_cause, 2'd1);
    check("L_mis_req0", imem_req, 0);
    repeat (3) cyc();
    check("L_mis_sticky", fault, 1);
    asyncreset = 0;
    cyc();

    // async reset mid-REQ, late ack during IDLE
    pc_in = 0; asyncreset = 1;
    cyc(); cyc();
    #2 asyncreset = 0; #1;
    check("L_ar_req", imem_req, 0);
    check("L_ar_valid", inst_valid, 0);
    cyc();
    asyncreset = 1; imem_ack = 1; imem_rdata = 32'hdead_beef; #1;
    check("L_late_req", imem_req, 0);
    cyc();
    imem_ack = 0; #1;
    check("L_late_valid", inst_valid, 0);
    check("L_late_out", inst_out, NOPW);

    // timeout at default TIMEOUT
    for (int i = 0; i < TO - 1; i++) cyc();
    check("L_to_last_req", imem_req, 1);
    check("L_to_last_fault", fault, 0);
    cyc();
    check("L_to_cause", fault_cause, 2'd3);

    // async reset mid-HOLD
    asyncreset = 0;
    cyc();
    asyncreset = 1;
    cyc();
    imem_ack = 1; imem_rdata = 32'h0000_0033;
    cyc();
    imem_ack = 0; inst_ready = 1; #1;
    check("L_ah_load", pc_load, 1);
    #2 asyncreset = 0; #1;
    check("L_ah_valid", inst_valid, 0);
    check("L_ah_load0", pc_load, 0);
    check("L_ah_out", inst_out, NOPW);
    cyc();
    inst_ready = 0; asyncreset = 1;
    repeat (3) cyc();

    // TIMEOUT=4 instance: expiry, then ack on the last allowed cycle
    rst4 = 1;
    repeat (4) cyc();
    check("L_t4_req", req4, 1);
    check("L_t4_addr", addr4, 32'h40);
    check("L_t4_nofault", fault4, 0);
    cyc();
    check("L_t4_fault", fault4, 1);
    check("L_t4_cause", cause4, 2'd3);
    check("L_t4_req0", req4, 0);
    rst4 = 0;
    cyc();
    rst4 = 1;
    repeat (4) cyc();
    ack4 = 1; rdata4 = 32'h1234_5678;
    cyc();
    ack4 = 0;
    check("L_t4b_valid", valid4, 1);
    check("L_t4b_fault", fault4, 0);
    check("L_t4b_out", out4, 32'h1234_5678);
    check("L_t4b_pc", ipc4, 32'h40);
    ready4 = 1; #1;
    check("L_t4b_load", pcload4, 1);
    cyc();
    ready4 = 0;
    check("L_t4b_done", valid4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
